// File: rtl/sfx_tone_player.sv
// rtl/sfx_tone_player.sv - falling-pitch square-wave laser burst feeding the audio output FIFO; optional decay under SFX_DECAY_EN
module sfx_tone_player #(
    parameter int          SAMPLE_DIV    = 1042,
    parameter int          START_HALF    = 50,
    parameter int          SWEEP_SAMPLES = 480,
    parameter int          DUR_SAMPLES   = 14400,
    parameter logic [31:0] AMP           = 32'h1000_0000,
    parameter bit          RETRIGGER     = 1'b1
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        trigger,
    input  logic        audio_out_allowed,
    output logic        write_audio_out,
    output logic [31:0] left_channel_audio_out,
    output logic [31:0] right_channel_audio_out,
    output logic        busy,
    output logic [7:0]  dropped_count
);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int IDX_W = $clog2(DUR_SAMPLES + 1);
    localparam int SWP_W = (SWEEP_SAMPLES > 1) ? $clog2(SWEEP_SAMPLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_END    = IDX_W'(DUR_SAMPLES);
    localparam logic [SWP_W-1:0] SWEEP_LAST = SWP_W'(SWEEP_SAMPLES - 1);
    localparam logic [9:0]       HALF_INIT  = 10'(START_HALF);
    localparam logic [9:0]       HALF_MAX   = 10'd1023;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic               trig_d;
    logic               edge_det;

    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_inc;
    logic [SWP_W-1:0]   sweep_cnt;
    logic               sweep_end;
    logic               last_sample;
    logic [9:0]         half;
    logic [9:0]         phase;
    logic               pol;
    logic signed [31:0] amp;

    logic               load_gen;
    logic               step_gen;
    logic               emit;

    logic [31:0]        sample;
    logic               pending;

    assign tick        = (div_cnt == DIV_LAST);
    assign edge_det    = trigger & ~trig_d;
    assign idx_inc     = idx + IDX_W'(1);
    assign last_sample = (idx_inc == IDX_END);
    assign sweep_end   = (sweep_cnt == SWEEP_LAST);

    assign write_audio_out         = pending & audio_out_allowed;
    assign left_channel_audio_out  = sample;
    assign right_channel_audio_out = sample;
    assign busy                    = (state == ST_PLAY) | pending;

    // Free-running sample-rate divider, independent of the FSM state.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Delayed copy of trigger for rising-edge detection.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            trig_d <= 1'b0;
        end else begin
            trig_d <= trigger;
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus generator strobes; an edge on the final tick starts a fresh burst.
    always_comb begin
        state_next = state;
        load_gen   = 1'b0;
        step_gen   = 1'b0;
        emit       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (edge_det) begin
                    state_next = ST_PLAY;
                    load_gen   = 1'b1;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    emit     = 1'b1;
                    step_gen = 1'b1;
                    if (last_sample) begin
                        state_next = ST_IDLE;
                    end
                end
                if (edge_det && (RETRIGGER || (tick && last_sample))) begin
                    state_next = ST_PLAY;
                    load_gen   = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Tone generator: square-wave phase, pitch sweep and amplitude.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            idx       <= '0;
            sweep_cnt <= '0;
            half      <= '0;
            phase     <= '0;
            pol       <= 1'b0;
            amp       <= '0;
        end else if (load_gen) begin
            idx       <= '0;
            sweep_cnt <= '0;
            half      <= HALF_INIT;
            phase     <= '0;
            pol       <= 1'b1;
            amp       <= AMP;
        end else if (step_gen) begin
            idx <= idx_inc;
            if (phase == half - 10'd1) begin
                pol   <= ~pol;
                phase <= '0;
            end else begin
                phase <= phase + 10'd1;
            end
            if (sweep_end) begin
                sweep_cnt <= '0;
                if (half != HALF_MAX) begin
                    half <= half + 10'd1;
                end
`ifdef SFX_DECAY_EN
                // amp is non-negative, so subtracting an eighth of it cannot go below 0.
                amp <= amp - (amp >>> 3);
`endif
            end else begin
                sweep_cnt <= sweep_cnt + SWP_W'(1);
            end
        end
    end

    // Output sample holding register, pending flag and overrun counter.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sample        <= '0;
            pending       <= 1'b0;
            dropped_count <= '0;
        end else if (emit) begin
            sample  <= pol ? amp : -amp;
            pending <= 1'b1;
            if (pending && !audio_out_allowed && (dropped_count != 8'hFF)) begin
                dropped_count <= dropped_count + 8'd1;
            end
        end else if (write_audio_out) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sfx_tone_player.sv
// tb/tb_sfx_tone_player.sv - scoreboard bench for sfx_tone_player with random trigger, backpressure and reset
module tb_sfx_tone_player;
    localparam int SD  = 4;
    localparam int SH  = 2;
    localparam int SW  = 4;
    localparam int DUR = 8;
    localparam int AM  = 100;
    localparam bit RT  = 1'b1;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        trigger = 1'b0;
    logic        allowed = 1'b0;
    logic        write_audio_out;
    logic [31:0] left_out;
    logic [31:0] right_out;
    logic        busy;
    logic [7:0]  dropped_count;

    int total = 0;
    int bad = 0;

    int wave [DUR];
    int exp_q [$];

    int m_cnt = 0;
    bit m_trig_d = 1'b0;
    bit m_play = 1'b0;
    int m_k = 0;
    bit m_pending = 1'b0;
    int m_dropped = 0;

    sfx_tone_player #(
        .SAMPLE_DIV(SD),
        .START_HALF(SH),
        .SWEEP_SAMPLES(SW),
        .DUR_SAMPLES(DUR),
        .AMP(32'(AM)),
        .RETRIGGER(RT)
    ) dut (
        .CLOCK_50(clk),
        .resetn(resetn),
        .trigger(trigger),
        .audio_out_allowed(allowed),
        .write_audio_out(write_audio_out),
        .left_channel_audio_out(left_out),
        .right_channel_audio_out(right_out),
        .busy(busy),
        .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Burst waveform as runs of equal sign: a run ends once its length reaches the
    // half-period in force for that sample; half and amplitude step every SW samples.
    function automatic void build_wave();
        int run = 0;
        int sign = 1;
        int a = AM;
        int h;
        for (int k = 0; k < DUR; k++) begin
`ifdef SFX_DECAY_EN
            if (k > 0 && (k % SW) == 0) a = a - (a >>> 3);
`endif
            h = SH + k / SW;
            if (h > 1023) h = 1023;
            wave[k] = sign * a;
            run++;
            if (run >= h) begin
                sign = -sign;
                run = 0;
            end
        end
    endfunction

    // Reference model, evaluated on the same edge as the DUT registers.
    initial begin
        bit edge_seen, tick, wr, was_play, final_tick;
        forever begin
            @(posedge clk);
            if (!resetn) begin
                m_cnt = 0; m_trig_d = 0; m_play = 0; m_k = 0;
                m_pending = 0; m_dropped = 0;
                exp_q.delete();
            end else begin
                edge_seen = trigger && !m_trig_d;
                m_trig_d = trigger;
                tick = (m_cnt == SD - 1);
                m_cnt = tick ? 0 : m_cnt + 1;
                wr = m_pending && allowed;
                was_play = m_play;
                final_tick = 0;
                if (m_play && tick) begin
                    if (m_pending && !wr) begin
                        if (exp_q.size() > 0) void'(exp_q.pop_back());
                        if (m_dropped < 255) m_dropped++;
                    end
                    exp_q.push_back(wave[m_k]);
                    m_pending = 1;
                    m_k++;
                    if (m_k == DUR) begin
                        m_play = 0;
                        final_tick = 1;
                    end
                end else if (wr) begin
                    m_pending = 0;
                end
                if (edge_seen && (!was_play || final_tick || RT)) begin
                    m_play = 1;
                    m_k = 0;
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model mid-cycle, pops on each write.
    initial begin
        int exp_v;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                check("reset_write", write_audio_out, 0);
                check("reset_busy", busy, 0);
                check("reset_data", left_out, 0);
                check("reset_dropped", dropped_count, 0);
            end else begin
                check("write_strobe", write_audio_out, m_pending && allowed);
                check("busy", busy, m_play || m_pending);
                check("dropped_count", dropped_count, m_dropped);
                check("right_eq_left", right_out, left_out);
                if (write_audio_out) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 1, 0);
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("sample_data", longint'($signed(left_out)), exp_v);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
    endtask

    initial begin
        int pct;
        int budget;
        build_wave();
        resetn = 1'b0;
        step(3);
        resetn = 1'b1;
        allowed = 1'b1;
        step(2);

        // basic burst
        pulse_trigger();
        step(45);

        // backpressure across one tick
        pulse_trigger();
        step(6);
        allowed = 1'b0;
        step(6);
        allowed = 1'b1;
        step(40);

        // overrun: two ticks without acceptance
        pulse_trigger();
        step(6);
        allowed = 1'b0;
        step(10);
        allowed = 1'b1;
        step(40);

        // retrigger after five samples
        pulse_trigger();
        step(21);
        pulse_trigger();
        step(45);

        // reset mid-burst
        pulse_trigger();
        step(14);
        resetn = 1'b0;
        step(2);
        resetn = 1'b1;
        step(20);

        // randomized traffic
        pct = 100;
        for (int c = 0; c < 8000; c++) begin
            if ((c % 200) == 0) begin
                case ($urandom_range(0, 2))
                    0: pct = 100;
                    1: pct = 70;
                    default: pct = 20;
                endcase
            end
            allowed = ($urandom_range(0, 99) < pct);
            if ($urandom_range(0, 99) < 3) trigger = 1'b1;
            else if ($urandom_range(0, 1) == 0) trigger = 1'b0;
            resetn = ($urandom_range(0, 1999) != 0);
            step(1);
        end

        // drain
        resetn = 1'b1;
        trigger = 1'b0;
        allowed = 1'b1;
        budget = 0;
        while ((m_play || m_pending) && budget < DUR * SD * 4 + 50) begin
            step(1);
            budget++;
        end
        step(2);
        check("drain_timeout", (m_play || m_pending) ? 1 : 0, 0);
        check("queue_empty", exp_q.size(), 0);
        check("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
